// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending controller with three coin values,
// per-item price and stock, cancel/refund, restock, and serial greedy change.
// Optional feature: define VM_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES
// consecutive idle cycles in COLLECT (default build has no timeout logic).
module vending_machine_multi #(
  parameter int CREDIT_W   = 8,
  parameter int NUM_ITEMS  = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd20, 8'd15},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  parameter int COIN1      = 5,
  parameter int COIN2      = 10,
  parameter int COIN3      = 25,
`ifdef VM_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 100,
`endif
  parameter int MAX_CREDIT = 50,
  localparam int SEL_W     = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  input  logic                restock,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                sold_out,
  output logic [1:0]          c_state,
  output logic [1:0]          n_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  localparam logic [CREDIT_W-1:0] C1   = CREDIT_W'(COIN1);
  localparam logic [CREDIT_W-1:0] C2   = CREDIT_W'(COIN2);
  localparam logic [CREDIT_W-1:0] C3   = CREDIT_W'(COIN3);
  localparam logic [CREDIT_W:0]   CMAX = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  SINIT = STOCK_W'(STOCK_INIT);

  state_t                            state_q, state_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock;
  logic [CREDIT_W-1:0]               credit_d, coin_v, price;
  logic [SEL_W-1:0]                  sel_idx, item_d;
  logic [1:0]                        change_d;
  logic sel_ok, buy_ok, coin_fits, out_d, reject_d, take, reload;

  // Out-of-range selects are clamped to item 0 for indexing but never sold.
  assign sel_ok   = int'(sel) < NUM_ITEMS;
  assign sel_idx  = sel_ok ? sel : '0;
  assign price    = PRICES[int'(sel_idx)*CREDIT_W +: CREDIT_W];
  assign sold_out = sel_ok && (stock[sel_idx] == '0);
  assign buy_ok   = sel_ok && (stock[sel_idx] != '0) && (credit >= price);
  // Sum is one bit wider so an overflowing coin is still seen as too large.
  assign coin_fits = ({1'b0, credit} + {1'b0, coin_v}) <= CMAX;
  assign c_state  = state_q;
  assign n_state  = state_d;

  // Decode coin code to its credit value.
  always_comb begin
    coin_v = '0;
    case (in)
      2'd1:    coin_v = C1;
      2'd2:    coin_v = C2;
      2'd3:    coin_v = C3;
      default: coin_v = '0;
    endcase
  end

`ifdef VM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] idle_cnt;
  logic             idle_tick, timeout;

  // An idle COLLECT cycle has no buy attempt, no cancel and no accepted coin.
  assign idle_tick = (state_q == COLLECT) && !cancel && !buy && !((in != 2'd0) && coin_fits);
  assign timeout   = idle_tick && (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive idle COLLECT cycles; any other cycle restarts the count.
  always_ff @(posedge clk or posedge rst)
    if (rst)            idle_cnt <= '0;
    else if (idle_tick) idle_cnt <= idle_cnt + TMR_W'(1);
    else                idle_cnt <= '0;
`endif

  // Next state, next credit and next registered outputs.
  always_comb begin
    state_d  = state_q;
    credit_d = credit;
    change_d = 2'd0;
    reject_d = 1'b0;
    out_d    = 1'b0;
    item_d   = item;
    take     = 1'b0;
    reload   = 1'b0;
    case (state_q)
      IDLE: begin
        reload = restock;
        if (in != 2'd0) begin
          if (coin_fits) begin
            credit_d = credit + coin_v;
            state_d  = COLLECT;
          end else reject_d = 1'b1;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d  = CHANGE;
          reject_d = (in != 2'd0);
        end else if (buy && buy_ok) begin
          credit_d = credit - price;
          take     = 1'b1;
          item_d   = sel_idx;
          out_d    = 1'b1;
          state_d  = VEND;
          reject_d = (in != 2'd0);
        end else begin
          if (in != 2'd0) begin
            if (coin_fits) credit_d = credit + coin_v;
            else           reject_d = 1'b1;
          end
`ifdef VM_TIMEOUT_EN
          if (timeout) state_d = CHANGE;
`endif
        end
      end
      VEND: begin
        reject_d = (in != 2'd0);
        state_d  = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = (in != 2'd0);
        if (credit == '0) state_d = IDLE;
      end
    endcase
    // Change is paid on every edge that lands in CHANGE, largest coin first,
    // so the first coin shows the cycle after the vend pulse or the cancel.
    if (state_d == CHANGE) begin
      if (credit_d >= C3) begin
        change_d = 2'd3;
        credit_d = credit_d - C3;
      end else if (credit_d >= C2) begin
        change_d = 2'd2;
        credit_d = credit_d - C2;
      end else if (credit_d >= C1) begin
        change_d = 2'd1;
        credit_d = credit_d - C1;
      end else begin
        // A remainder below the smallest coin cannot be paid; drop it.
        credit_d = '0;
      end
    end
  end

  // State, credit, stock and registered outputs.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      credit      <= '0;
      out         <= 1'b0;
      item        <= '0;
      change      <= 2'd0;
      coin_reject <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= SINIT;
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      out         <= out_d;
      item        <= item_d;
      change      <= change_d;
      coin_reject <= reject_d;
      if (reload) begin
        for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= SINIT;
      end else if (take) begin
        stock[sel_idx] <= stock[sel_idx] - STOCK_W'(1);
      end
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed scenarios plus random transactions checked
// against a transaction-level model (credit total, stock counts, greedy refund list).
module tb_vending_machine_multi;

  localparam int MAXC  = 50;
  localparam int SINIT = 2;

  int cv[4]    = '{0, 5, 10, 25};
  int price[2] = '{15, 20};

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] in = 2'd0;
  logic [0:0] sel = 1'b0;
  logic       buy = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic       out, coin_reject, sold_out;
  logic [0:0] item;
  logic [1:0] change, c_state, n_state;
  logic [7:0] credit;

  int tests = 0, fails = 0;
  int m_credit = 0;
  int m_stock[2] = '{2, 2};
  int m_item = 0;

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .buy(buy), .cancel(cancel),
    .restock(restock), .out(out), .item(item), .change(change),
    .coin_reject(coin_reject), .credit(credit), .sold_out(sold_out),
    .c_state(c_state), .n_state(n_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Refund the model's credit greedily and check each change coin, then IDLE.
  // Inputs for the first edge are set by the caller; later edges get random
  // coins/buys/restocks, all of which must be ignored or rejected.
  task automatic drain();
    int rem, code;
    logic [1:0] cin;
    rem = m_credit;
    while (rem > 0) begin
      code = (rem >= cv[3]) ? 3 : (rem >= cv[2]) ? 2 : 1;
      rem -= cv[code];
      cin = in;
      step();
      cancel = 1'b0;
      in = 2'($urandom_range(0, 3));
      buy = 1'($urandom_range(0, 1));
      restock = 1'($urandom_range(0, 1));
      chk("chg_coin", change, code);
      chk("chg_credit", credit, rem);
      chk("chg_reject", coin_reject, cin != 2'd0);
      chk("chg_state", c_state, 3);
      chk("chg_out", out, 0);
    end
    cin = in;
    step();
    in = 2'd0; buy = 1'b0; cancel = 1'b0; restock = 1'b0;
    chk("end_change", change, 0);
    chk("end_state", c_state, 0);
    chk("end_credit", credit, 0);
    chk("end_reject", coin_reject, cin != 2'd0);
    chk("end_out", out, 0);
    m_credit = 0;
  endtask

  // One cycle of activity from IDLE or COLLECT, predicted by the model.
  task automatic act(input int c, input bit b, input int s, input bit k, input bit r);
    bit idle, vend, canc, rej;
    idle = (m_credit == 0); vend = 1'b0; canc = 1'b0; rej = 1'b0;
    in = 2'(c); buy = b; sel = 1'(s); cancel = k; restock = r;
    #1;
    chk("sold_out", sold_out, m_stock[s] == 0);
    if (idle) begin
      if (r) foreach (m_stock[i]) m_stock[i] = SINIT;
      if (c != 0) begin
        if (cv[c] <= MAXC) m_credit = cv[c];
        else rej = 1'b1;
      end
    end else if (k) begin
      canc = 1'b1;
      rej = (c != 0);
    end else if (b && m_stock[s] > 0 && m_credit >= price[s]) begin
      vend = 1'b1;
      rej = (c != 0);
      m_credit -= price[s];
      m_stock[s]--;
      m_item = s;
    end else if (c != 0) begin
      if (m_credit + cv[c] <= MAXC) m_credit += cv[c];
      else rej = 1'b1;
    end
    chk("n_state", n_state, canc ? 3 : vend ? 2 : (m_credit > 0 ? 1 : 0));
    if (canc) begin
      drain();
      return;
    end
    step();
    in = 2'd0; buy = 1'b0; cancel = 1'b0; restock = 1'b0;
    chk("out", out, vend);
    chk("item", item, m_item);
    chk("credit", credit, m_credit);
    chk("coin_reject", coin_reject, rej);
    chk("change", change, 0);
    chk("c_state", c_state, vend ? 2 : (m_credit > 0 ? 1 : 0));
    if (vend) begin
      in = 2'($urandom_range(0, 3));
      drain();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_state", c_state, 0);
    chk("rst_credit", credit, 0);
    chk("rst_out", out, 0);
    chk("rst_change", change, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_item", item, 0);
    chk("rst_sold_out", sold_out, 0);
    rst = 1'b0;
    step();

    // Exact payment, no change
    act(1, 0, 0, 0, 0); act(1, 0, 0, 0, 0); act(1, 0, 0, 0, 0);
    chk("t1_credit", credit, 15);
    act(0, 1, 0, 0, 0);

    // Overpayment by one small coin
    act(2, 0, 0, 0, 0); act(2, 0, 0, 0, 0);
    act(0, 1, 0, 0, 0);

    // Cancel refunds 25 + 25
    act(3, 0, 0, 0, 0); act(3, 0, 0, 0, 0);
    chk("t3_credit", credit, 50);
    act(0, 0, 0, 1, 0);

    // Sell out item 0, keep credit, refund, restock
    act(0, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) begin
      act(1, 0, 0, 0, 0); act(1, 0, 0, 0, 0); act(1, 0, 0, 0, 0);
      act(0, 1, 0, 0, 0);
    end
    chk("t4_sold_out", sold_out, 1);
    chk("t4_credit", credit, 15);
    act(0, 0, 0, 1, 0);
    act(0, 0, 0, 0, 1);
    #1;
    chk("t4_restocked", sold_out, 0);

    // Credit ceiling and item 1
    act(3, 0, 0, 0, 0); act(3, 0, 0, 0, 0); act(2, 0, 0, 0, 0);
    chk("t5_reject", coin_reject, 1);
    chk("t5_credit", credit, 50);
    act(0, 1, 1, 0, 0);

    // Async reset in the middle of paying change
    act(3, 0, 0, 0, 0); act(3, 0, 0, 0, 0);
    buy = 1'b1; sel = 1'b0;
    step();
    buy = 1'b0;
    chk("t6_out", out, 1);
    chk("t6_vend_credit", credit, 35);
    step();
    chk("t6_change", change, 3);
    chk("t6_chg_credit", credit, 10);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_state", c_state, 0);
    chk("t6_rst_change", change, 0);
    chk("t6_rst_credit", credit, 0);
    #1 rst = 1'b0;
    m_credit = 0; m_item = 0;
    foreach (m_stock[i]) m_stock[i] = SINIT;
    step();

`ifdef VM_TIMEOUT_EN
    // Auto-refund after the idle limit
    act(2, 0, 0, 0, 0);
    repeat (99) step();
    chk("to_waiting", c_state, 1);
    step();
    chk("to_change", change, 2);
    chk("to_credit", credit, 0);
    step();
    chk("to_idle", c_state, 0);
    chk("to_idle_change", change, 0);
    m_credit = 0;
`endif

    // Random transactions
    for (int n = 0; n < 400; n++)
      act($urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
          $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
